// File: rtl/tpu_dma_pkg.sv
// Shared opcode map and FSM state type for the host-side DMA controller.
// Opcode helpers take the configuration so every instance derives its own map.
package tpu_dma_pkg;

  localparam int unsigned DEF_N_CH = 3;
  localparam int unsigned DEF_OP_W = 3;

  function automatic int unsigned op_ch(input int unsigned k);
    return k + 1;
  endfunction

  function automatic int unsigned op_start_of(input int unsigned n_ch);
    return n_ch + 1;
  endfunction

  function automatic int unsigned op_abort_of(input int unsigned op_w);
    return (1 << op_w) - 2;
  endfunction

  function automatic int unsigned op_data_of(input int unsigned op_w);
    return (1 << op_w) - 1;
  endfunction

  localparam int unsigned OP_NOP   = 0;
  localparam int unsigned OP_START = DEF_N_CH + 1;
  localparam int unsigned OP_ABORT = (1 << DEF_OP_W) - 2;
  localparam int unsigned OP_DATA  = (1 << DEF_OP_W) - 1;

  typedef enum logic {
    StIdle,
    StBurst
  } dma_state_e;

endpackage

// File: rtl/dma_cmd_decode.sv
// Combinational split of the host command word into fields and opcode class flags.
module dma_cmd_decode
  import tpu_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned N_CH   = 3,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [OP_W+ADDR_W:0] uio_in,
  output logic                 burst,
  output logic [ADDR_W-1:0]    addr,
  output logic                 is_ch,
  output logic [CH_W-1:0]      ch_idx,
  output logic                 is_start,
  output logic                 is_data,
  output logic                 is_abort,
  output logic                 is_nop,
  output logic                 is_rsvd
);

  localparam logic [OP_W-1:0] OpStart = OP_W'(op_start_of(N_CH));
  localparam logic [OP_W-1:0] OpAbort = OP_W'(op_abort_of(OP_W));
  localparam logic [OP_W-1:0] OpData  = OP_W'(op_data_of(OP_W));
  localparam logic [OP_W-1:0] OpLast  = OP_W'(N_CH);
  localparam logic [OP_W-1:0] OpOne   = OP_W'(op_ch(0));

  logic [OP_W-1:0] op;

  always_comb begin
    op       = uio_in[OP_W+ADDR_W:ADDR_W+1];
    burst    = uio_in[ADDR_W];
    addr     = uio_in[ADDR_W-1:0];
    is_nop   = (op == '0);
    is_ch    = (op >= OpOne) && (op <= OpLast);
    ch_idx   = CH_W'(op - OpOne);
    is_start = (op == OpStart);
    is_abort = (op == OpAbort);
    is_data  = (op == OpData);
    is_rsvd  = !(is_nop || is_ch || is_start || is_abort || is_data);
  end

endmodule

// File: rtl/dma_ctrl.sv
// Host DMA sequencer: single/burst writes into N_CH memories plus compute start pulse.
// Every output is a register updated from the command sampled on the previous edge.
module dma_ctrl
  import tpu_dma_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned N_CH   = 3,
  parameter int unsigned OP_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W+ADDR_W:0] uio_in,
  input  logic [DATA_W-1:0]    ui_in,
  output logic [N_CH-1:0]      wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 start,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              burst, is_ch, is_start, is_data, is_abort, is_nop, is_rsvd;
  logic [ADDR_W-1:0] addr;
  logic [CH_W-1:0]   ch_idx;

  dma_cmd_decode #(
    .ADDR_W (ADDR_W),
    .N_CH   (N_CH),
    .OP_W   (OP_W),
    .CH_W   (CH_W)
  ) u_decode (
    .uio_in   (uio_in),
    .burst    (burst),
    .addr     (addr),
    .is_ch    (is_ch),
    .ch_idx   (ch_idx),
    .is_start (is_start),
    .is_data  (is_data),
    .is_abort (is_abort),
    .is_nop   (is_nop),
    .is_rsvd  (is_rsvd)
  );

  dma_state_e        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  // One extra bit so a full 2^ADDR_W burst length is representable.
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [N_CH-1:0]   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (is_ch) begin
          if (burst) begin
            ch_d    = ch_idx;
            ptr_d   = addr;
            cnt_d   = {1'b0, ui_in[ADDR_W-1:0]} + 1'b1;
            state_d = StBurst;
          end else begin
            wr_en_d[ch_idx] = 1'b1;
            wr_addr_d       = addr;
            wr_data_d       = ui_in;
          end
        end else if (is_start) begin
          start_d = 1'b1;
        end else if (is_data || is_abort || is_rsvd) begin
          err_d = 1'b1;
        end
      end
      StBurst: begin
        if (is_data) begin
          wr_en_d[ch_q] = 1'b1;
          wr_addr_d     = ptr_q;
          wr_data_d     = ui_in;
          ptr_d         = ptr_q + 1'b1;
          cnt_d         = cnt_q - 1'b1;
          if (cnt_q == (ADDR_W+1)'(1)) state_d = StIdle;
        end else if (is_abort) begin
          state_d = StIdle;
        end else if (!is_nop) begin
          err_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StBurst);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign start   = start_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: stimulus queues expected writes/start pulses,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_dma_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] uio_in;
  logic [7:0] ui_in;
  logic [2:0] wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       err;

  dma_ctrl #(
    .DATA_W (8),
    .ADDR_W (4),
    .N_CH   (3),
    .OP_W   (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uio_in  (uio_in),
    .ui_in   (ui_in),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .err     (err)
  );

  typedef struct packed {
    logic [2:0] en;
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_starts = 0;
  int  checks = 0;
  int  errors = 0;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] START = 8'h80;
  localparam logic [7:0] ABORT = 8'hC0;
  localparam logic [7:0] DATA  = 8'hE0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one command for one clock; on return the resulting outputs are visible.
  task automatic drive(input logic [7:0] u, input logic [7:0] d);
    uio_in = u;
    ui_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [2:0] en, input logic [3:0] a, input logic [7:0] d);
    wr_t w;
    w.en   = en;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got en=%b addr=%0h data=%0h, none expected",
                   wr_en, wr_addr, wr_data);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          check("wr_en", 32'(wr_en), 32'(w.en));
          check("wr_addr", 32'(wr_addr), 32'(w.addr));
          check("wr_data", 32'(wr_data), 32'(w.data));
        end
      end
      if (start) begin
        checks++;
        if (exp_starts == 0) begin
          errors++;
          $display("FAIL unexpected_start: got start=1, expected 0");
        end else begin
          exp_starts--;
        end
      end
    end
  end

  task automatic check_drained(input string name);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_starts_left"}, 32'(exp_starts), 32'd0);
  endtask

  initial begin
    reset  = 1'b0;
    uio_in = 8'h00;
    ui_in  = 8'h00;
    #2;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single write, op1 addr5.
    exp_wr(3'b001, 4'd5, 8'hA7);
    drive(8'h25, 8'hA7);
    drive(NOP, 8'h00);
    check("single_en_clears", 32'(wr_en), 32'd0);

    // Burst of 3 on channel 1 from addr 14 with a NOP stall.
    drive(8'h5E, 8'h02);
    check("b3_busy_cmd", 32'(busy), 32'd1);
    exp_wr(3'b010, 4'd14, 8'h11);
    drive(DATA, 8'h11);
    drive(NOP, 8'h00);
    check("b3_busy_stall", 32'(busy), 32'd1);
    exp_wr(3'b010, 4'd15, 8'h22);
    drive(DATA, 8'h22);
    exp_wr(3'b010, 4'd0, 8'h33);
    drive(DATA, 8'h33);
    check("b3_busy_last", 32'(busy), 32'd0);
    drive(NOP, 8'h00);
    check("b3_err", 32'(err), 32'd0);

    // Abort after 2 of 5 beats, channel 0 from addr 1.
    drive(8'h31, 8'h04);
    exp_wr(3'b001, 4'd1, 8'hA1);
    drive(DATA, 8'hA1);
    exp_wr(3'b001, 4'd2, 8'hA2);
    drive(DATA, 8'hA2);
    drive(ABORT, 8'h00);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    drive(NOP, 8'h00);

    // START: one cycle gives one pulse, two cycles give two.
    exp_starts = 1;
    drive(START, 8'h00);
    drive(NOP, 8'h00);
    check("start_once", 32'(start), 32'd0);
    exp_starts += 2;
    drive(START, 8'h00);
    drive(START, 8'h00);
    drive(NOP, 8'h00);

    // START mid-burst: no pulse, err set, burst completes.
    drive(8'h5A, 8'h01);
    drive(START, 8'h00);
    check("sib_err", 32'(err), 32'd1);
    check("sib_busy", 32'(busy), 32'd1);
    exp_wr(3'b010, 4'd10, 8'h61);
    drive(DATA, 8'h61);
    exp_wr(3'b010, 4'd11, 8'h62);
    drive(DATA, 8'h62);
    check("sib_busy_end", 32'(busy), 32'd0);
    drive(NOP, 8'h00);
    check_drained("phase1");

    // Clear sticky err.
    #2 reset = 1'b0;
    #1 check("err_cleared", 32'(err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Full 16-beat burst on channel 2 from addr 9, wrapping; 17th beat errors.
    drive(8'h79, 8'h0F);
    for (int i = 0; i < 16; i++) begin
      exp_wr(3'b100, 4'((9 + i) % 16), 8'(8'h40 + i));
      drive(DATA, 8'(8'h40 + i));
    end
    check("b16_busy_end", 32'(busy), 32'd0);
    check("b16_err_before", 32'(err), 32'd0);
    drive(DATA, 8'h99);
    check("b16_err_extra", 32'(err), 32'd1);
    drive(NOP, 8'h00);
    check_drained("phase2");

    // Async reset between edges mid-burst; the in-flight strobe is dropped.
    drive(8'h3F, 8'h03);
    exp_wr(3'b001, 4'd15, 8'h70);
    drive(DATA, 8'h70);
    drive(DATA, 8'h71);
    #1 reset = 1'b0;
    #1;
    check("ar_wr_en", 32'(wr_en), 32'd0);
    check("ar_wr_addr", 32'(wr_addr), 32'd0);
    check("ar_wr_data", 32'(wr_data), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_err", 32'(err), 32'd0);
    uio_in = NOP;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_wr(3'b010, 4'd7, 8'hBD);
    drive(8'h47, 8'hBD);
    drive(NOP, 8'h00);
    check("post_busy", 32'(busy), 32'd0);
    drive(NOP, 8'h00);
    check_drained("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Parametrised host-side DMA controller for the TPU. Decodes command words from the bidirectional host bus (uio_in) and sequences single or burst writes of host data (ui_in) into N_CH on-chip memories (weights, inputs, instructions).
- Issues the compute start pulse.
- Sits between the top-level pins and the memory write ports / TPU control unit. Outputs are registered, stateful strobes rather than level decodes.

Parameters:
- DATA_W, 8: width of ui_in data and wr_data.
- ADDR_W, 4: memory address width. Burst addresses wrap modulo 2^ADDR_W.
- N_CH, 3: number of target memories. Channel k (0-based) uses opcode k+1.
- OP_W, 3: opcode field width. Requires N_CH+2 < 2^OP_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- uio_in  in  OP_W+1+ADDR_W  command word: [top OP_W bits]=opcode, [ADDR_W]=burst flag, [ADDR_W-1:0]=address
- ui_in  in  DATA_W  data beat, or burst count on a burst command cycle
- wr_en  out  N_CH  one-hot memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  DATA_W  write data
- start  out  1  one-cycle compute start pulse
- busy  out  1  high while a burst is in progress
- err  out  1  sticky protocol-error flag

Behaviour:
- Opcodes:
  - 0 = NOP
  - 1..N_CH = channel write
  - N_CH+1 = START
  - 2^OP_W-2 = ABORT
  - 2^OP_W-1 = DATA
  - all others reserved
- Reset (reset low, asynchronous): state=IDLE; wr_en=0, wr_addr=0, wr_data=0, start=0, busy=0, err=0, count=0.
- All outputs are registered. Command sampled at edge N takes effect in cycle N+1. wr_en and start are single-cycle unless re-triggered.
- States are IDLE and BURST.
- IDLE, channel opcode, burst=0 (single write):
  - Next cycle: wr_en[ch]=1, wr_addr=addr field, wr_data=ui_in sampled at N.
  - State stays IDLE, so back-to-back singles are accepted every cycle.
- IDLE, channel opcode, burst=1:
  - Latch ch and base addr.
  - count = ui_in[ADDR_W-1:0]+1, range 1..2^ADDR_W.
  - Go to BURST; busy=1 from N+1. No write this cycle.
- BURST, DATA opcode:
  - Write ui_in to the latched ch at the current pointer, one cycle later.
  - Pointer increments mod 2^ADDR_W; count decrements.
  - On the beat that takes count to 0: return to IDLE; busy=0 in the same cycle the last write is presented.
- BURST, NOP: stall. No write, no count change.
- BURST, ABORT: return to IDLE, no write, busy=0 next cycle, err unchanged.
- BURST, any other opcode (channel, START, reserved): ignored, err=1, burst continues.
- IDLE, START: start=1 in cycle N+1 for one cycle. START held k cycles gives k pulses.
- IDLE, DATA / ABORT / reserved: ignored, err=1.
- IDLE, NOP: nothing.
- err clears only on reset.
- Burst flag on non-channel opcodes is don't-care.
- Reset asserted mid-burst aborts immediately. A write strobe in flight is dropped.

Decomposition:
- Package tpu_dma_pkg holds:
  - opcode localparams / function op_ch(k)
  - OP_NOP, OP_START, OP_ABORT, OP_DATA derived from N_CH and OP_W
  - state enum {IDLE, BURST}
- Sub-module dma_cmd_decode: purely combinational. Splits uio_in into fields and produces is_ch, ch_idx, is_start, is_data, is_abort, is_nop, is_rsvd.
- dma_ctrl holds the FSM, pointer/count registers and output registers.

Test Plan:
- Reset, then uio_in=0x25 (op1, single, addr5), ui_in=0xA7 -> next cycle wr_en=3'b001, wr_addr=5, wr_data=0xA7; following cycle wr_en=0.
- Burst: uio_in=0x5E (op2, burst, addr14), ui_in=0x02 (count 3), then DATA beats 0x11, NOP, 0x22, 0x33 -> wr_en=3'b010 at addrs 14, 15, 0 with data 0x11/0x22/0x33, one idle gap at the NOP; busy high from the command+1 through the last write, low afterwards.
- Burst count ui_in=0x0F -> 16 writes covering all addresses, wrapping back to the base; the 17th DATA beat sets err=1 with no write.
- START (0x80) for one cycle -> start=1 for exactly one cycle. START issued during BURST -> no pulse, err=1, burst completes normally.
- ABORT (0xC0) after 2 of 5 burst beats -> exactly 2 writes, busy low next cycle, err=0.
- reset driven low asynchronously mid-burst, between clock edges -> all outputs 0 immediately. After release, a single write works normally.
